// File: rtl/mmc_capture_pkg.sv
// Shared definitions for the MMC/SD CMD-line frame sniffer: state encoding, default
// frame lengths, the command set that announces a long response, and the serial CRC7 step.
package mmc_capture_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StTrans = 3'd1;
  localparam state_t StRecv  = 3'd2;
  localparam state_t StEnd   = 3'd3;
  localparam state_t StPush  = 3'd4;

  localparam int unsigned ShortLenDefault = 48;
  localparam int unsigned LongLenDefault  = 136;

  // CMD2, CMD9 and CMD10 are answered with a 136-bit R2 response.
  localparam logic [63:0] LongCmdMask = (64'd1 << 2) | (64'd1 << 9) | (64'd1 << 10);

  function automatic logic is_long_cmd(input logic [5:0] idx);
    return LongCmdMask[idx];
  endfunction

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

endpackage

// File: rtl/mmc_frame_capture_if.sv
// Readout handshake for captured frames: FWFT head-of-queue data plus a pop strobe.
interface mmc_frame_capture_if
  import mmc_capture_pkg::*;
#(
  parameter int unsigned LONG_LEN = LongLenDefault
);
  logic [LONG_LEN-1:0] msg_packet;
  logic                msg_long;
  logic                msg_dir;
  logic                msg_crc_ok;
  logic                msg_end_ok;
  logic                msg_valid;
  logic                msg_ready;

  modport master (
    output msg_packet, msg_long, msg_dir, msg_crc_ok, msg_end_ok, msg_valid,
    input  msg_ready
  );

  modport slave (
    input  msg_packet, msg_long, msg_dir, msg_crc_ok, msg_end_ok, msg_valid,
    output msg_ready
  );
endinterface

// File: rtl/mmc_frame_fifo.sv
// First-word-fall-through frame queue; a push into a full queue succeeds only if the
// head is popped in the same cycle. Read data is forced to zero while empty.
module mmc_frame_fifo #(
  parameter int unsigned WIDTH = 140,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      push_ok,
  input  logic                      pop_ready,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_en, pop;

  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid & pop_ready;
  assign push_ok  = (count_q != CntW'(DEPTH)) | pop;
  assign wr_en    = push & push_ok;
  assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mmc_frame_capture.sv
// Passive MMC/SD CMD-line sniffer: oversamples the bus in the clk domain, frames host
// commands and card responses (48 or 136 bits), checks CRC7 and end bit, and queues them.
module mmc_frame_capture
  import mmc_capture_pkg::*;
#(
  parameter int unsigned LONG_LEN   = LongLenDefault,
  parameter int unsigned SHORT_LEN  = ShortLenDefault,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_i,
  input  logic                        capture_en,
  input  logic                        mmc_clk,
  input  logic                        mmc_cmd,
  mmc_frame_capture_if.master         msg,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                 overflow_cnt,
  output logic [2:0]                  debug_state,
  output logic [8:0]                  debug_cnt
);
  localparam int unsigned EntryW = LONG_LEN + 4;

  logic [1:0]          clk_sync_q, cmd_sync_q;
  logic                clk_dly_q, cmd_dly_q;
  logic                mmc_edge, mmc_bit;

  state_t              state_q, state_d;
  logic [8:0]          cnt_q, cnt_d, cnt_inc, target;
  logic [LONG_LEN-1:0] shreg_q, shreg_d, shift_in;
  logic [6:0]          crc_q, crc_d;
  logic                dir_q, dir_d, long_q, long_d, end_ok_q, end_ok_d;
  logic                long_pending_q, long_pending_d;
  logic [15:0]         overflow_q, overflow_d;
  logic                crc_cover, crc_ok, push, push_ok, rd_valid;
  logic [EntryW-1:0]   rd_data;

  // Clock and data share identical delay, so the delayed data bit is the one set up
  // before the detected rising edge.
  assign mmc_edge = clk_sync_q[1] & ~clk_dly_q;
  assign mmc_bit  = cmd_dly_q;

  assign cnt_inc  = cnt_q + 9'd1;
  assign target   = long_q ? 9'(LONG_LEN) : 9'(SHORT_LEN);
  assign shift_in = {shreg_q[LONG_LEN-2:0], mmc_bit};
  assign crc_ok   = (crc_q == shreg_q[7:1]);
  // Long frames skip start, direction and the reserved field ahead of bit 127.
  assign crc_cover = long_q ? (cnt_inc >= 9'd9 && cnt_inc <= 9'(LONG_LEN - 8))
                            : (cnt_inc <= 9'(SHORT_LEN - 8));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    crc_d          = crc_q;
    dir_d          = dir_q;
    long_d         = long_q;
    end_ok_d       = end_ok_q;
    long_pending_d = long_pending_q;
    push           = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (mmc_edge && !mmc_bit && capture_en) begin
          state_d = StTrans;
          cnt_d   = 9'd1;
          shreg_d = {{(LONG_LEN-1){1'b0}}, mmc_bit};
          crc_d   = '0;
        end
      end
      StTrans: begin
        if (mmc_edge) begin
          shreg_d = shift_in;
          cnt_d   = cnt_inc;
          dir_d   = mmc_bit;
          long_d  = !mmc_bit && long_pending_q;
          if (!long_d) crc_d = crc7_next(crc_q, mmc_bit);
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (mmc_edge) begin
          shreg_d = shift_in;
          cnt_d   = cnt_inc;
          if (crc_cover) crc_d = crc7_next(crc_q, mmc_bit);
          if (cnt_inc == target - 9'd1) state_d = StEnd;
        end
      end
      StEnd: begin
        if (mmc_edge) begin
          shreg_d  = shift_in;
          cnt_d    = cnt_inc;
          end_ok_d = mmc_bit;
          state_d  = StPush;
        end
      end
      StPush: begin
        push           = 1'b1;
        cnt_d          = '0;
        long_pending_d = dir_q && is_long_cmd(shreg_q[SHORT_LEN-3 -: 6]);
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (push && !push_ok && overflow_q != 16'hFFFF) overflow_d = overflow_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      clk_sync_q     <= '0;
      cmd_sync_q     <= '0;
      clk_dly_q      <= 1'b0;
      cmd_dly_q      <= 1'b0;
      state_q        <= StIdle;
      cnt_q          <= '0;
      shreg_q        <= '0;
      crc_q          <= '0;
      dir_q          <= 1'b0;
      long_q         <= 1'b0;
      end_ok_q       <= 1'b0;
      long_pending_q <= 1'b0;
      overflow_q     <= '0;
    end else begin
      clk_sync_q     <= {clk_sync_q[0], mmc_clk};
      cmd_sync_q     <= {cmd_sync_q[0], mmc_cmd};
      clk_dly_q      <= clk_sync_q[1];
      cmd_dly_q      <= cmd_sync_q[1];
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      crc_q          <= crc_d;
      dir_q          <= dir_d;
      long_q         <= long_d;
      end_ok_q       <= end_ok_d;
      long_pending_q <= long_pending_d;
      overflow_q     <= overflow_d;
    end
  end

  mmc_frame_fifo #(
    .WIDTH(EntryW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_i  (reset_i),
    .push     (push),
    .wr_data  ({shreg_q, long_q, dir_q, crc_ok, end_ok_q}),
    .push_ok  (push_ok),
    .pop_ready(msg.msg_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (fifo_count)
  );

  assign {msg.msg_packet, msg.msg_long, msg.msg_dir, msg.msg_crc_ok, msg.msg_end_ok} = rd_data;
  assign msg.msg_valid = rd_valid;
  assign overflow_cnt  = overflow_q;
  assign debug_state   = state_q;
  assign debug_cnt     = cnt_q;

endmodule
